spi_slave: RTL

SPI slave endpoint that pairs with the team's `spi_master`. It receives a serial word on `mosi` and simultaneously returns a parallel-loaded word on `miso`, MSB first, in any of the four CPOL/CPHA modes. All SPI pins are asynchronous to `clk` and are oversampled through synchronizers. The block sits at the device or peripheral side of the bus and presents a parallel word plus a one-cycle valid pulse to local logic.

---
 rtl/spi_slave_if.sv | 27 ++
 rtl/spi_slave.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/spi_slave_if.sv
// SPI slave bus bundle: serial pins toward the master plus the parallel
// word/handshake side toward local logic.
interface spi_slave_if #(
    parameter int DATA_WIDTH = 16
);
    logic                  sclk;
    logic                  cs_n;
    logic                  mosi;
    logic                  miso;
    logic                  miso_oe;
    logic [DATA_WIDTH-1:0] tx_data;
    logic                  tx_load;
    logic [DATA_WIDTH-1:0] data_out;
    logic                  rx_valid;
    logic                  frame_err;
    logic                  busy;

    modport slave (
        input  sclk, cs_n, mosi, tx_data,
        output miso, miso_oe, tx_load, data_out, rx_valid, frame_err, busy
    );

    modport master (
        output sclk, cs_n, mosi, tx_data,
        input  miso, miso_oe, tx_load, data_out, rx_valid, frame_err, busy
    );
endinterface

// File: rtl/spi_slave.sv
// SPI slave endpoint: oversamples sclk/cs_n/mosi into clk, receives one word
// MSB first while returning a word captured at frame start; all four modes.
module spi_slave #(
    parameter int DATA_WIDTH = 16,
    parameter bit CPOL       = 1'b0,
    parameter bit CPHA       = 1'b0
) (
    input logic        clk,
    input logic        rst_n,
    spi_slave_if.slave bus
);
    localparam int              CW   = $clog2(DATA_WIDTH) + 1;
    localparam logic [CW-1:0]   LAST = CW'(DATA_WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        ACTIVE,
        HOLD
    } state_t;

    state_t                state;
    logic [2:0]            sclk_sr;
    logic [2:0]            cs_sr;
    logic [2:0]            mosi_sr;
    logic                  lead_q;
    logic                  trail_q;
    logic                  cs_fall_q;
    logic                  cs_rise_q;
    logic [DATA_WIDTH-1:0] tx_sr;
    logic [DATA_WIDTH-1:0] rx_sr;
    logic [CW-1:0]         bit_cnt;
    logic                  first_seen;
    logic                  sample_ev;
    logic                  shift_ev;

    // Stages [1:0] are the synchronizer, [2] is history; edges compare [1] vs [2]
    // and are registered so every edge reaches the FSM with the same latency.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_sr   <= {3{CPOL}};
            cs_sr     <= '0;
            mosi_sr   <= '0;
            lead_q    <= 1'b0;
            trail_q   <= 1'b0;
            cs_fall_q <= 1'b0;
            cs_rise_q <= 1'b0;
        end else begin
            sclk_sr   <= {sclk_sr[1:0], bus.sclk};
            cs_sr     <= {cs_sr[1:0], bus.cs_n};
            mosi_sr   <= {mosi_sr[1:0], bus.mosi};
            lead_q    <= (sclk_sr[2] == CPOL) && (sclk_sr[1] != CPOL);
            trail_q   <= (sclk_sr[2] != CPOL) && (sclk_sr[1] == CPOL);
            cs_fall_q <= cs_sr[2] && !cs_sr[1];
            cs_rise_q <= !cs_sr[2] && cs_sr[1];
        end
    end

    always_comb begin
        sample_ev = CPHA ? trail_q : lead_q;
        shift_ev  = CPHA ? lead_q  : trail_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            tx_sr         <= '0;
            rx_sr         <= '0;
            bit_cnt       <= '0;
            first_seen    <= 1'b0;
            bus.miso      <= 1'b0;
            bus.miso_oe   <= 1'b0;
            bus.tx_load   <= 1'b0;
            bus.data_out  <= '0;
            bus.rx_valid  <= 1'b0;
            bus.frame_err <= 1'b0;
            bus.busy      <= 1'b0;
        end else begin
            bus.tx_load   <= 1'b0;
            bus.rx_valid  <= 1'b0;
            bus.frame_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (cs_fall_q) begin
                        tx_sr       <= bus.tx_data;
                        bit_cnt     <= '0;
                        first_seen  <= 1'b0;
                        bus.miso    <= bus.tx_data[DATA_WIDTH-1];
                        bus.miso_oe <= 1'b1;
                        bus.busy    <= 1'b1;
                        bus.tx_load <= 1'b1;
                        state       <= ACTIVE;
                    end
                end
                ACTIVE: begin
                    if (sample_ev) begin
                        rx_sr   <= {rx_sr[DATA_WIDTH-2:0], mosi_sr[2]};
                        bit_cnt <= bit_cnt + CW'(1);
                    end
                    // With CPHA=1 the MSB is already on miso, so the first leading
                    // edge only arms the shifter.
                    if (shift_ev) begin
                        if (CPHA && !first_seen) begin
                            first_seen <= 1'b1;
                        end else begin
                            tx_sr    <= {tx_sr[DATA_WIDTH-2:0], 1'b0};
                            bus.miso <= tx_sr[DATA_WIDTH-2];
                        end
                    end
                    // A cs_n rise coinciding with the last sample still completes the word.
                    if (sample_ev && (bit_cnt == LAST)) begin
                        bus.data_out <= {rx_sr[DATA_WIDTH-2:0], mosi_sr[2]};
                        bus.rx_valid <= 1'b1;
                        bus.miso     <= 1'b0;
                        if (cs_rise_q) begin
                            bus.miso_oe <= 1'b0;
                            bus.busy    <= 1'b0;
                            state       <= IDLE;
                        end else begin
                            state <= HOLD;
                        end
                    end else if (cs_rise_q) begin
                        bus.frame_err <= 1'b1;
                        bus.miso      <= 1'b0;
                        bus.miso_oe   <= 1'b0;
                        bus.busy      <= 1'b0;
                        state         <= IDLE;
                    end
                end
                HOLD: begin
                    bus.miso <= 1'b0;
                    if (cs_rise_q) begin
                        bus.miso_oe <= 1'b0;
                        bus.busy    <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: begin
                    bus.miso    <= 1'b0;
                    bus.miso_oe <= 1'b0;
                    bus.busy    <= 1'b0;
                    state       <= IDLE;
                end
            endcase
        end
    end
endmodule
